// File: rtl/eq_frame_checker_if.sv
// Handshake bundle between the XNOR comparator stage, the frame checker and
// the downstream controller. err_sticky exists only with EQ_CHECK_STICKY_EN.
interface eq_frame_checker_if #(
  parameter int CNT_W = 4
);
  logic             clr;
  logic             in_valid;
  logic             in_eq;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_match;
  logic [CNT_W-1:0] out_mismatches;
  logic [CNT_W-1:0] out_first_err;
`ifdef EQ_CHECK_STICKY_EN
  logic             err_sticky;

  modport master (
    output clr, in_valid, in_eq, out_ready,
    input  in_ready, out_valid, out_match, out_mismatches, out_first_err, err_sticky
  );
  modport slave (
    input  clr, in_valid, in_eq, out_ready,
    output in_ready, out_valid, out_match, out_mismatches, out_first_err, err_sticky
  );
`else
  modport master (
    output clr, in_valid, in_eq, out_ready,
    input  in_ready, out_valid, out_match, out_mismatches, out_first_err
  );
  modport slave (
    input  clr, in_valid, in_eq, out_ready,
    output in_ready, out_valid, out_match, out_mismatches, out_first_err
  );
`endif
endinterface

// File: rtl/eq_frame_checker.sv
// Frame-level equality checker: collects FRAME_LEN XNOR result bits and
// holds a registered match / mismatch-count / first-error report on a
// valid/ready output. Optional macro EQ_CHECK_STICKY_EN adds err_sticky,
// a flag set by any mismatching report and cleared only by rst_n.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting bits (in_ready = 1), counting mismatches
// REPORT  | report held on out_valid until out_ready; input stalled
module eq_frame_checker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  eq_frame_checker_if.slave bus
);

  typedef enum logic {S_COLLECT = 1'b0, S_REPORT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(FRAME_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bit_idx;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_first_idx;
  logic             r_match;
  logic [CNT_W-1:0] r_mism;
  logic [CNT_W-1:0] r_first;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic [CNT_W-1:0] w_err_nxt;
  logic [CNT_W-1:0] w_first_nxt;

  // Accept decode and the counter values that include the bit on the bus
  always_comb begin
    w_accept    = bus.in_valid & w_in_ready;
    w_last      = w_accept && (r_bit_idx == LP_LAST);
    w_err_nxt   = r_err_cnt + {{(CNT_W-1){1'b0}}, ~bus.in_eq};
    w_first_nxt = (!bus.in_eq && (r_err_cnt == '0)) ? r_bit_idx : r_first_idx;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; clr overrides everything
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: if (w_last)        w_state_nxt = S_REPORT;
        S_REPORT:  if (bus.out_ready) w_state_nxt = S_COLLECT;
        default:                      w_state_nxt = S_COLLECT;
      endcase
    end
  end

  // Handshake outputs depend on state only
  always_comb begin
    w_in_ready  = (r_state == S_COLLECT);
    w_out_valid = (r_state == S_REPORT);
  end

  // Per-frame counters: bit index, mismatch count, first mismatch index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx   <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
    end else if (bus.clr || w_last) begin
      r_bit_idx   <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
    end else if (w_accept) begin
      r_bit_idx   <= r_bit_idx + 1'b1;
      r_err_cnt   <= w_err_nxt;
      r_first_idx <= w_first_nxt;
    end
  end

  // Report registers, latched on the final bit of a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match <= 1'b0;
      r_mism  <= '0;
      r_first <= '0;
    end else if (bus.clr) begin
      r_match <= 1'b0;
      r_mism  <= '0;
      r_first <= '0;
    end else if (w_last) begin
      r_match <= (w_err_nxt == '0);
      r_mism  <= w_err_nxt;
      r_first <= w_first_nxt;
    end
  end

`ifdef EQ_CHECK_STICKY_EN
  logic r_sticky;

  // Sticky error flag: survives clr and handshakes, only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_sticky <= 1'b0;
    else if (!bus.clr && w_last && (w_err_nxt != '0)) r_sticky <= 1'b1;
  end

  assign bus.err_sticky = r_sticky;
`endif

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_match      = r_match;
  assign bus.out_mismatches = r_mism;
  assign bus.out_first_err  = r_first;

endmodule
